// File: rtl/pe_config_loader_pkg.sv
// Shared definitions for the PE tile configuration loader: FSM state
// encoding, error codes and the frame word-count derivation.
package pe_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_PARITY = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_COMMIT = 3'd4
    } pe_cfg_state_e;

    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_SHORT  = 2'b01;
    localparam logic [1:0] ERR_LONG   = 2'b10;
    localparam logic [1:0] ERR_PARITY = 2'b11;

    // Number of data words needed to cover nbits configuration bits.
    function automatic int num_words(input int nbits, input int dw);
        return (nbits + dw - 1) / dw;
    endfunction

endpackage

// File: rtl/pe_config_loader_if.sv
// Configuration word stream (valid/ready with end-of-frame marker).
interface pe_config_loader_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] cfg_data;
    logic                  cfg_valid;
    logic                  cfg_last;
    logic                  cfg_ready;

    modport master (
        output cfg_data,
        output cfg_valid,
        output cfg_last,
        input  cfg_ready
    );

    modport slave (
        input  cfg_data,
        input  cfg_valid,
        input  cfg_last,
        output cfg_ready
    );
endinterface

// File: rtl/pe_config_loader.sv
// Frame-based configuration loader for the PE tile switch matrix.
// Words are assembled into a shadow register; only a complete, well-formed
// frame is committed atomically to ConfigBits / ConfigBits_N.
// Optional build macro: PE_CFG_PARITY_EN adds a parity trailer word per frame.
module pe_config_loader
    import pe_cfg_pkg::*;
#(
    parameter int NoConfigBits = 23,
    parameter int DATA_WIDTH   = 8
) (
    input  logic                    UserCLK,
    input  logic                    reset,
    pe_config_loader_if.slave       cfg,
    input  logic                    cfg_err_clr,
    output logic [NoConfigBits-1:0] ConfigBits,
    output logic [NoConfigBits-1:0] ConfigBits_N,
    output logic                    cfg_busy,
    output logic                    cfg_done,
    output logic                    cfg_err,
    output logic [1:0]              cfg_err_code
);

    localparam int NUM_WORDS = num_words(NoConfigBits, DATA_WIDTH);
    localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    localparam logic [2:0] S_IDLE   = ST_IDLE;
    localparam logic [2:0] S_LOAD   = ST_LOAD;
    localparam logic [2:0] S_DRAIN  = ST_DRAIN;
    localparam logic [2:0] S_COMMIT = ST_COMMIT;
`ifdef PE_CFG_PARITY_EN
    localparam logic [2:0] S_PARITY = ST_PARITY;
`endif

    logic [2:0]              state;
    logic [2:0]              state_nxt;
    logic [IDX_W-1:0]        cnt;
    logic [IDX_W-1:0]        cnt_nxt;
    logic [IDX_W-1:0]        widx;
    logic [NoConfigBits-1:0] shadow;
    logic                    ready_q;
    logic                    xfer;
    logic                    wr_en;
    logic                    final_word;
    logic                    commit;
    logic                    err_set;
    logic [1:0]              err_set_code;

    assign cfg.cfg_ready = ready_q;

    // Next-state, word-index and error-detection logic for the frame FSM.
    always_comb begin
        xfer         = cfg.cfg_valid && ready_q;
        widx         = (state == S_LOAD) ? cnt : '0;
        final_word   = (widx == LAST_IDX);
        wr_en        = xfer && ((state == S_IDLE) || (state == S_LOAD));
        commit       = (state == S_COMMIT);
        state_nxt    = state;
        cnt_nxt      = cnt;
        err_set      = 1'b0;
        err_set_code = ERR_NONE;

        case (state)
            S_IDLE, S_LOAD: begin
                if (xfer) begin
                    if (!final_word) begin
                        if (cfg.cfg_last) begin
                            state_nxt    = S_IDLE;
                            cnt_nxt      = '0;
                            err_set      = 1'b1;
                            err_set_code = ERR_SHORT;
                        end else begin
                            state_nxt = S_LOAD;
                            cnt_nxt   = widx + IDX_W'(1);
                        end
                    end else begin
                        cnt_nxt = '0;
`ifdef PE_CFG_PARITY_EN
                        // The end marker belongs on the trailer, not on a data word.
                        if (cfg.cfg_last) begin
                            state_nxt    = S_IDLE;
                            err_set      = 1'b1;
                            err_set_code = ERR_SHORT;
                        end else begin
                            state_nxt = S_PARITY;
                        end
`else
                        if (cfg.cfg_last) begin
                            state_nxt = S_COMMIT;
                        end else begin
                            state_nxt    = S_DRAIN;
                            err_set      = 1'b1;
                            err_set_code = ERR_LONG;
                        end
`endif
                    end
                end
            end
`ifdef PE_CFG_PARITY_EN
            S_PARITY: begin
                // A missing end marker takes precedence: the rest of the frame must be drained.
                if (xfer) begin
                    if (!cfg.cfg_last) begin
                        state_nxt    = S_DRAIN;
                        err_set      = 1'b1;
                        err_set_code = ERR_LONG;
                    end else if (cfg.cfg_data[0] != (^shadow)) begin
                        state_nxt    = S_IDLE;
                        err_set      = 1'b1;
                        err_set_code = ERR_PARITY;
                    end else begin
                        state_nxt = S_COMMIT;
                    end
                end
            end
`endif
            S_DRAIN: begin
                if (xfer && cfg.cfg_last) begin
                    state_nxt = S_IDLE;
                end
            end
            S_COMMIT: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Control state, registered handshake/status outputs and the active configuration.
    always_ff @(posedge UserCLK) begin
        if (reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            ready_q      <= 1'b1;
            cfg_busy     <= 1'b0;
            cfg_done     <= 1'b0;
            cfg_err      <= 1'b0;
            cfg_err_code <= ERR_NONE;
            ConfigBits   <= '0;
            ConfigBits_N <= '1;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            ready_q  <= (state_nxt != S_COMMIT);
            cfg_busy <= (state_nxt != S_IDLE);
            cfg_done <= commit;
            if (commit) begin
                ConfigBits   <= shadow;
                ConfigBits_N <= ~shadow;
            end
            if (err_set) begin
                cfg_err      <= 1'b1;
                cfg_err_code <= err_set_code;
            end else if (cfg_err_clr) begin
                cfg_err      <= 1'b0;
                cfg_err_code <= ERR_NONE;
            end
        end
    end

    // Shadow register: each bit is loaded from its own word slot; padding bits of the
    // last word have no storage at all.
    for (genvar k = 0; k < NoConfigBits; k++) begin : g_shadow
        localparam logic [IDX_W-1:0] WORD_SEL = IDX_W'(k / DATA_WIDTH);
        always_ff @(posedge UserCLK) begin
            if (wr_en && (widx == WORD_SEL)) begin
                shadow[k] <= cfg.cfg_data[k % DATA_WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_pe_config_loader.sv
// Randomized self-checking bench for pe_config_loader with a frame-level
// reference model (frame length / parity rules evaluated per whole frame).
module tb_pe_config_loader;
    import pe_cfg_pkg::*;

    localparam int NCB = 23;
    localparam int DW  = 8;
    localparam int NW  = num_words(NCB, DW);
`ifdef PE_CFG_PARITY_EN
    localparam int NW_EFF = NW + 1;
`else
    localparam int NW_EFF = NW;
`endif

    logic           UserCLK = 1'b0;
    logic           reset = 1'b1;
    logic           cfg_err_clr = 1'b0;
    logic [NCB-1:0] ConfigBits;
    logic [NCB-1:0] ConfigBits_N;
    logic           cfg_busy;
    logic           cfg_done;
    logic           cfg_err;
    logic [1:0]     cfg_err_code;

    pe_config_loader_if #(.DATA_WIDTH(DW)) cfg ();

    pe_config_loader #(.NoConfigBits(NCB), .DATA_WIDTH(DW)) dut (
        .UserCLK      (UserCLK),
        .reset        (reset),
        .cfg          (cfg),
        .cfg_err_clr  (cfg_err_clr),
        .ConfigBits   (ConfigBits),
        .ConfigBits_N (ConfigBits_N),
        .cfg_busy     (cfg_busy),
        .cfg_done     (cfg_done),
        .cfg_err      (cfg_err),
        .cfg_err_code (cfg_err_code)
    );

    always #5 UserCLK = ~UserCLK;

    int n_vec = 0;
    int n_err = 0;
    int done_cnt = 0;
    int exp_done = 0;
    logic [NCB-1:0] exp_cfg = '0;
    logic           exp_err = 1'b0;
    logic [1:0]     exp_code = 2'b00;

    always @(negedge UserCLK) begin
        if (cfg_done === 1'b1) done_cnt++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge UserCLK);
        #1;
    endtask

    task automatic send_word(input logic [7:0] d, input logic l, input int max_gap);
        int   gap;
        bit   ok;
        logic r;
        gap = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
        cfg.cfg_valid = 1'b0;
        repeat (gap) tick();
        cfg.cfg_data  = d;
        cfg.cfg_last  = l;
        cfg.cfg_valid = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 50 && !ok; c++) begin
            r = cfg.cfg_ready;
            tick();
            if (r) ok = 1'b1;
        end
        cfg.cfg_valid = 1'b0;
        check_val("xfer_accepted", {31'd0, ok}, 32'd1);
    endtask

    function automatic logic [NCB-1:0] frame_value(input logic [7:0] w[$]);
        logic [NW*DW-1:0] wide;
        wide = '0;
        for (int i = 0; i < NW && i < w.size(); i++) wide[i*DW +: DW] = w[i];
        return wide[NCB-1:0];
    endfunction

    task automatic check_status(input string tag);
        logic [NCB-1:0] ncfg;
        ncfg = ~exp_cfg;
        check_val({tag, "_cfg"}, ConfigBits, exp_cfg);
        check_val({tag, "_cfg_n"}, ConfigBits_N, ncfg);
        check_val({tag, "_err"}, cfg_err, exp_err);
        check_val({tag, "_code"}, cfg_err_code, exp_code);
    endtask

    // Sends one frame (end marker on the last word) and checks the outcome
    // predicted from the frame's length and content.
    task automatic run_frame(input string tag, input logic [7:0] w[$], input int max_gap,
                             input bit clr_final);
        int             n;
        logic [NCB-1:0] val;
        logic [NCB-1:0] nval;
        logic [NCB-1:0] old;
        logic [1:0]     code;
        bit             good;
        n    = w.size();
        val  = frame_value(w);
        nval = ~val;
        good = 1'b0;
        code = ERR_NONE;
        if (n < NW_EFF) code = ERR_SHORT;
        else if (n > NW_EFF) code = ERR_LONG;
        else begin
`ifdef PE_CFG_PARITY_EN
            if (w[NW][0] != (^val)) code = ERR_PARITY;
            else good = 1'b1;
`else
            good = 1'b1;
`endif
        end
        check_val({tag, "_done_count"}, done_cnt, exp_done);
        old = exp_cfg;
        for (int i = 0; i < n; i++) begin
            if (clr_final && i == n - 1) cfg_err_clr = 1'b1;
            send_word(w[i], (i == n - 1), max_gap);
            cfg_err_clr = 1'b0;
        end
        if (good) begin
            check_val({tag, "_commit_ready"}, cfg.cfg_ready, 1'b0);
            check_val({tag, "_commit_busy"}, cfg_busy, 1'b1);
            check_val({tag, "_cfg_hold"}, ConfigBits, old);
            tick();
            exp_cfg = val;
            exp_done++;
            check_val({tag, "_cfg_new"}, ConfigBits, val);
            check_val({tag, "_cfg_n_new"}, ConfigBits_N, nval);
            check_val({tag, "_done"}, cfg_done, 1'b1);
            check_val({tag, "_ready_after"}, cfg.cfg_ready, 1'b1);
            check_val({tag, "_busy_after"}, cfg_busy, 1'b0);
            @(negedge UserCLK);
            #1;
        end else begin
            exp_err  = 1'b1;
            exp_code = code;
            check_status(tag);
            check_val({tag, "_busy"}, cfg_busy, 1'b0);
            check_val({tag, "_done"}, cfg_done, 1'b0);
        end
    endtask

    task automatic clear_err();
        cfg_err_clr = 1'b1;
        tick();
        cfg_err_clr = 1'b0;
        exp_err  = 1'b0;
        exp_code = ERR_NONE;
        check_val("clr_err", cfg_err, 1'b0);
        check_val("clr_code", cfg_err_code, 2'b00);
    endtask

    function automatic logic [7:0] with_trailer_bit(input logic [7:0] w[$], input logic [7:0] t,
                                                    input bit flip);
        logic [7:0] r;
        r    = t;
        r[0] = (^frame_value(w)) ^ flip;
        return r;
    endfunction

    initial begin
        logic [7:0] q[$];
        int         r;
        int         n;

        cfg.cfg_valid = 1'b0;
        cfg.cfg_last  = 1'b0;
        cfg.cfg_data  = '0;
        repeat (3) tick();
        reset = 1'b0;

        check_status("reset");
        check_val("reset_ready", cfg.cfg_ready, 1'b1);
        check_val("reset_busy", cfg_busy, 1'b0);
        check_val("reset_done", cfg_done, 1'b0);

        // Good frame, then a second frame starting in the cfg_done cycle.
        q = '{8'h55, 8'hAA, 8'h7F};
`ifdef PE_CFG_PARITY_EN
        q.push_back(with_trailer_bit(q, 8'h00, 1'b0));
`endif
        run_frame("good", q, 0, 1'b0);
        check_val("good_literal", ConfigBits, 23'h7FAA55);
        check_val("good_literal_n", ConfigBits_N, 23'h0055AA);
        q = '{8'h12, 8'h34, 8'h56};
`ifdef PE_CFG_PARITY_EN
        q.push_back(with_trailer_bit(q, 8'hF0, 1'b0));
`endif
        run_frame("b2b", q, 0, 1'b0);

        // Short frame, then clear.
        q = '{8'h01, 8'h02};
        run_frame("short", q, 0, 1'b0);
        clear_err();

        // Long frame: one word beyond the expected frame length.
        q.delete();
        for (int i = 0; i <= NW_EFF; i++) q.push_back(8'(8'hC0 + i));
        run_frame("long", q, 0, 1'b0);

        // A new error in the same cycle as the clear request wins.
        q = '{8'h03, 8'h04};
        run_frame("err_vs_clr", q, 0, 1'b1);
        clear_err();

        // Good frame with random valid gaps.
        q = '{8'h55, 8'hAA, 8'h7F};
`ifdef PE_CFG_PARITY_EN
        q.push_back(with_trailer_bit(q, 8'h00, 1'b0));
`endif
        run_frame("gaps", q, 4, 1'b0);

`ifdef PE_CFG_PARITY_EN
        q = '{8'h01, 8'h00, 8'h00, 8'h01};
        run_frame("par_good", q, 0, 1'b0);
        check_val("par_literal", ConfigBits, 23'h000001);
        q = '{8'h01, 8'h00, 8'h00, 8'h00};
        run_frame("par_bad", q, 0, 1'b0);
        clear_err();
`endif

        // Reset in the middle of a frame.
        send_word(8'hEE, 1'b0, 0);
        send_word(8'hDD, 1'b0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_cfg  = '0;
        exp_err  = 1'b0;
        exp_code = ERR_NONE;
        check_status("midreset");
        check_val("midreset_n_literal", ConfigBits_N, 23'h7FFFFF);
        check_val("midreset_ready", cfg.cfg_ready, 1'b1);
        check_val("midreset_busy", cfg_busy, 1'b0);
        q = '{8'h9A, 8'hBC, 8'h3E};
`ifdef PE_CFG_PARITY_EN
        q.push_back(with_trailer_bit(q, 8'h00, 1'b0));
`endif
        run_frame("after_reset", q, 1, 1'b0);

        // Randomized frames of varying length and content.
        for (int f = 0; f < 60; f++) begin
            r = $urandom_range(9, 0);
            if (r < 6) n = NW_EFF;
            else if (r < 8) n = $urandom_range(NW_EFF - 1, 1);
            else n = $urandom_range(NW_EFF + 2, NW_EFF + 1);
            q.delete();
            for (int i = 0; i < n; i++) q.push_back(8'($urandom));
`ifdef PE_CFG_PARITY_EN
            if (n == NW_EFF) q[NW] = with_trailer_bit(q, q[NW], (r == 5));
`endif
            if ($urandom_range(4, 0) == 0) clear_err();
            run_frame("rand", q, $urandom_range(3, 0), 1'b0);
        end

        repeat (3) tick();
        check_val("final_done_count", done_cnt, exp_done);
        check_status("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
